// File: rtl/hf_mode_sequencer.sv
// hf_mode_sequencer
// Takes the ARM's 16-bit SPI configuration frames, decodes SET_CONFREG and
// applies the major mode and sub-mode bits. A major-mode change waits for an
// SSP frame boundary, blanks every output for a guard interval and only then
// loads the new mode. This keeps the carrier and the SSP stream from ever
// seeing a half-finished switch.

module hf_mode_sequencer #(
    parameter int GUARD_CYCLES  = 16,
    parameter int DRAIN_TIMEOUT = 256
) (
    input  logic       ck_1356meg,
    input  logic       rst,
    input  logic       spck,
    input  logic       mosi,
    input  logic       ncs,
    input  logic       ssp_frame_in,
    output logic [2:0] major_mode,
    output logic [4:0] sub_conf,
    output logic       busy,
    output logic       cmd_err
);

    // The drain and guard intervals never overlap, so one counter serves both.
    localparam int CNT_MAX = (DRAIN_TIMEOUT > GUARD_CYCLES) ? DRAIN_TIMEOUT : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]       MODE_OFF   = 3'b111;
    localparam logic [3:0]       CMD_CONFREG = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_BLANK = 2'd2,
        ST_LOAD  = 2'd3
    } state_t;

    // SPI pin synchronisers and the delayed copies used for edge detection
    logic spck_meta, spck_sync, spck_prev;
    logic mosi_meta, mosi_sync;
    logic ncs_meta,  ncs_sync,  ncs_prev;

    logic spck_rise;
    logic ncs_rise;
    logic ncs_fall;

    // Frame assembly
    logic [15:0] shift_reg;
    logic [4:0]  bit_cnt;
    logic        frame_ok;

    // Registered frame decode, valid for one cycle after the ncs rise
    logic        frame_cmd;
    logic        frame_err;
    logic [7:0]  frame_tgt;

    // Sequencer state
    state_t      state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [7:0]  target, target_nx;
    logic [7:0]  pend_tgt, pend_tgt_nx;
    logic        pend_valid, pend_valid_nx;
    logic [2:0]  mode_nx;
    logic [4:0]  sub_nx;
    logic        busy_nx;

    // Scratch decisions for the idle-state command handling
    logic        cmd_take;
    logic [7:0]  cmd_tgt;

    // Two-flop synchronisers for the asynchronous SPI pins. The ncs chain
    // resets to its deasserted level so that leaving reset cannot look like a
    // frame end and produce a spurious reject.
    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            spck_meta <= 1'b0;
            spck_sync <= 1'b0;
            spck_prev <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
            ncs_meta  <= 1'b1;
            ncs_sync  <= 1'b1;
            ncs_prev  <= 1'b1;
        end else begin
            spck_meta <= spck;
            spck_sync <= spck_meta;
            spck_prev <= spck_sync;
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
            ncs_meta  <= ncs;
            ncs_sync  <= ncs_meta;
            ncs_prev  <= ncs_sync;
        end
    end

    assign spck_rise = spck_sync & ~spck_prev;
    assign ncs_rise  = ncs_sync & ~ncs_prev;
    assign ncs_fall  = ~ncs_sync & ncs_prev;

    // A frame is accepted only when exactly 16 bits arrived and the top
    // nibble carries the SET_CONFREG opcode.
    assign frame_ok = (bit_cnt == 5'd16) && (shift_reg[15:12] == CMD_CONFREG);

    // Shift MOSI in on each SPI clock rise inside the frame. The bit counter
    // saturates so that overlong frames still read as wrong-length.
    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            shift_reg <= 16'h0000;
            bit_cnt   <= 5'd0;
        end else if (ncs_fall) begin
            bit_cnt <= 5'd0;
        end else if (spck_rise && !ncs_sync) begin
            shift_reg <= {shift_reg[14:0], mosi_sync};
            if (bit_cnt != 5'd31) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    // Register the frame verdict at the chip-select rise. The sequencer acts
    // on it on the following edge.
    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            frame_cmd <= 1'b0;
            frame_err <= 1'b0;
            frame_tgt <= 8'h00;
        end else begin
            frame_cmd <= ncs_rise && frame_ok;
            frame_err <= ncs_rise && !frame_ok;
            if (ncs_rise) begin
                frame_tgt <= shift_reg[7:0];
            end
        end
    end

    // Sequencer registers. All outputs come straight from flops.
    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            target     <= 8'h00;
            pend_tgt   <= 8'h00;
            pend_valid <= 1'b0;
            major_mode <= MODE_OFF;
            sub_conf   <= 5'b00000;
            busy       <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            target     <= target_nx;
            pend_tgt   <= pend_tgt_nx;
            pend_valid <= pend_valid_nx;
            major_mode <= mode_nx;
            sub_conf   <= sub_nx;
            busy       <= busy_nx;
            cmd_err    <= frame_err;
        end
    end

    // Next-state and output logic. In IDLE, a fresh command takes priority
    // over a parked one. During DRAIN and BLANK, a new command only retargets
    // the switch. A command that lands in LOAD is parked until IDLE.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        target_nx     = target;
        pend_tgt_nx   = pend_tgt;
        pend_valid_nx = pend_valid;
        mode_nx       = major_mode;
        sub_nx        = sub_conf;
        busy_nx       = busy;
        cmd_take      = 1'b0;
        cmd_tgt       = frame_tgt;

        case (state)
            ST_IDLE: begin
                if (frame_cmd) begin
                    cmd_take = 1'b1;
                    cmd_tgt  = frame_tgt;
                end else if (pend_valid) begin
                    cmd_take = 1'b1;
                    cmd_tgt  = pend_tgt;
                end

                if (cmd_take) begin
                    pend_valid_nx = 1'b0;
                    if (cmd_tgt[7:5] == major_mode) begin
                        sub_nx = cmd_tgt[4:0];
                    end else begin
                        target_nx = cmd_tgt;
                        cnt_nx    = '0;
                        busy_nx   = 1'b1;
                        state_nx  = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (frame_cmd) begin
                    target_nx = frame_tgt;
                end
                if (!ssp_frame_in || (cnt == DRAIN_LAST)) begin
                    cnt_nx   = '0;
                    mode_nx  = MODE_OFF;
                    sub_nx   = 5'b00000;
                    state_nx = ST_BLANK;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end

            ST_BLANK: begin
                if (frame_cmd) begin
                    target_nx = frame_tgt;
                end
                if (cnt == GUARD_LAST) begin
                    cnt_nx   = '0;
                    state_nx = ST_LOAD;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end

            ST_LOAD: begin
                if (frame_cmd) begin
                    pend_tgt_nx   = frame_tgt;
                    pend_valid_nx = 1'b1;
                end
                mode_nx  = target[7:5];
                sub_nx   = target[4:0];
                busy_nx  = 1'b0;
                state_nx = ST_IDLE;
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hf_mode_sequencer.sv
// tb_hf_mode_sequencer
// Drives SPI frames and ssp_frame_in into hf_mode_sequencer and checks every
// output on every cycle against a timeline model. The model works from
// absolute cycle stamps: when the switch started, when blanking began and
// when the new mode is due.

module tb_hf_mode_sequencer;

    localparam int GUARD     = 16;
    localparam int DRAIN     = 256;
    localparam int FRAME_ACT = 107;

    logic       ck_1356meg = 1'b0;
    logic       rst = 1'b1;
    logic       spck = 1'b0;
    logic       mosi = 1'b0;
    logic       ncs = 1'b1;
    logic       ssp_frame_in = 1'b0;
    logic [2:0] major_mode;
    logic [4:0] sub_conf;
    logic       busy;
    logic       cmd_err;

    hf_mode_sequencer #(
        .GUARD_CYCLES (GUARD),
        .DRAIN_TIMEOUT(DRAIN)
    ) dut (
        .ck_1356meg  (ck_1356meg),
        .rst         (rst),
        .spck        (spck),
        .mosi        (mosi),
        .ncs         (ncs),
        .ssp_frame_in(ssp_frame_in),
        .major_mode  (major_mode),
        .sub_conf    (sub_conf),
        .busy        (busy),
        .cmd_err     (cmd_err)
    );

    // 10-unit clock period
    always #5 ck_1356meg = ~ck_1356meg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ssp_mode = 0;
    int seen_off = 0;

    // Frame events, each stamped with the edge at which the sequencer acts on it
    int         act_q[$];
    logic [7:0] tgt_q[$];
    bit         ok_q[$];
    int         rd_idx = 0;

    // Model state: the expected outputs plus the stamps of the switch in flight
    logic [2:0] exp_mode = 3'b111;
    logic [4:0] exp_sub = 5'd0;
    logic       exp_busy = 1'b0;
    logic       exp_err = 1'b0;
    bit         sw_active = 1'b0;
    int         drain_at = 0;
    int         blank_at = -1;
    logic [7:0] m_tgt = 8'h00;
    logic [7:0] m_pend = 8'h00;
    bit         m_pend_valid = 1'b0;

    // Compare one observed value with its expected value and count the result
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Start a switch or apply a same-mode sub update, whichever the command calls for
    task automatic modelCommand(input logic [7:0] t, input int n);
        if (t[7:5] == exp_mode) begin
            exp_sub = t[4:0];
        end else begin
            sw_active = 1'b1;
            drain_at  = n;
            blank_at  = -1;
            m_tgt     = t;
            exp_busy  = 1'b1;
        end
    endtask

    // Advance the model by one clock edge n
    task automatic modelStep(input int n);
        bit         ev;
        bit         ev_ok;
        logic [7:0] ev_tgt;
        bit         was_active;
        bit         in_load;
        ev = 1'b0;
        ev_ok = 1'b0;
        ev_tgt = 8'h00;
        exp_err = 1'b0;
        if (rd_idx < act_q.size() && act_q[rd_idx] == n) begin
            ev = 1'b1;
            ev_ok = ok_q[rd_idx];
            ev_tgt = tgt_q[rd_idx];
            rd_idx++;
        end
        was_active = sw_active;
        in_load = sw_active && (blank_at >= 0) && (n - 1 == blank_at + GUARD);
        if (ev && !ev_ok) exp_err = 1'b1;
        if (ev && ev_ok) begin
            if (!was_active) begin
                m_pend_valid = 1'b0;
                modelCommand(ev_tgt, n);
            end else if (in_load) begin
                m_pend = ev_tgt;
                m_pend_valid = 1'b1;
            end else begin
                m_tgt = ev_tgt;
            end
        end else if (!was_active && m_pend_valid) begin
            m_pend_valid = 1'b0;
            modelCommand(m_pend, n);
        end
        if (was_active) begin
            if (blank_at < 0) begin
                if (!ssp_frame_in || (n - drain_at == DRAIN)) begin
                    blank_at = n;
                    exp_mode = 3'b111;
                    exp_sub  = 5'd0;
                end
            end else if (n == blank_at + GUARD + 1) begin
                exp_mode  = m_tgt[7:5];
                exp_sub   = m_tgt[4:0];
                exp_busy  = 1'b0;
                sw_active = 1'b0;
            end
        end
    endtask

    // Edge counter and model update. A reset drops any frame not yet acted on.
    always @(posedge ck_1356meg) begin
        cyc = cyc + 1;
        if (rst) begin
            exp_mode = 3'b111;
            exp_sub = 5'd0;
            exp_busy = 1'b0;
            exp_err = 1'b0;
            sw_active = 1'b0;
            blank_at = -1;
            m_pend_valid = 1'b0;
            rd_idx = act_q.size();
        end else begin
            modelStep(cyc);
        end
    end

    // Wait one cycle, check all outputs at the falling edge and drive ssp_frame_in
    task automatic tick();
        @(negedge ck_1356meg);
        if (!rst) begin
            checkOutput("outs", {22'd0, major_mode, sub_conf, busy, cmd_err},
                        {22'd0, exp_mode, exp_sub, exp_busy, exp_err});
            if (major_mode == 3'b111) seen_off++;
        end
        case (ssp_mode)
            0:       ssp_frame_in = 1'b0;
            1:       ssp_frame_in = 1'b1;
            default: ssp_frame_in = ($urandom_range(0, 9) != 0);
        endcase
    endtask

    task automatic waitUntil(input int e);
        while (cyc < e) tick();
    endtask

    // Send one SPI frame MSB first, with each spck phase lasting 3 cycles.
    // Returns the edge at which the sequencer acts on the frame.
    task automatic applyStimulus(input logic [31:0] value, input int nbits, output int act);
        ncs = 1'b0;
        repeat (4) tick();
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = value[i];
            repeat (3) tick();
            spck = 1'b1;
            repeat (3) tick();
            spck = 1'b0;
        end
        repeat (3) tick();
        ncs = 1'b1;
        act = cyc + 4;
        act_q.push_back(act);
        tgt_q.push_back(value[7:0]);
        ok_q.push_back((nbits == 16) && (value[15:12] == 4'b0001));
        repeat (2) tick();
    endtask

    initial begin
        int a;
        int a2;
        int errs;
        int nb;
        logic [31:0] v;

        // Reset state
        repeat (3) tick();
        checkOutput("rst_mode", {29'd0, major_mode}, 32'd7);
        checkOutput("rst_sub", {27'd0, sub_conf}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_err", {31'd0, cmd_err}, 32'd0);
        rst = 1'b0;
        repeat (5) tick();

        // Switch from reset to mode 001 while ssp_frame_in is already low
        ssp_mode = 0;
        applyStimulus(32'h1020, 16, a);
        waitUntil(a + GUARD + 1);
        checkOutput("sw_blank_mode", {29'd0, major_mode}, 32'd7);
        checkOutput("sw_blank_busy", {31'd0, busy}, 32'd1);
        waitUntil(a + GUARD + 2);
        checkOutput("sw_mode", {29'd0, major_mode}, 32'd1);
        checkOutput("sw_busy", {31'd0, busy}, 32'd0);
        checkOutput("sw_sub", {27'd0, sub_conf}, 32'd0);

        // Same-mode update touches only sub_conf, one edge after decode
        applyStimulus(32'h1024, 16, a);
        waitUntil(a - 1);
        checkOutput("same_sub_before", {27'd0, sub_conf}, 32'd0);
        waitUntil(a);
        checkOutput("same_sub", {27'd0, sub_conf}, 32'd4);
        checkOutput("same_busy", {31'd0, busy}, 32'd0);
        checkOutput("same_mode", {29'd0, major_mode}, 32'd1);

        // Drain timeout: ssp_frame_in never drops
        ssp_mode = 1;
        seen_off = 0;
        applyStimulus(32'h1040, 16, a);
        waitUntil(a + DRAIN - 1);
        checkOutput("drain_hold_mode", {29'd0, major_mode}, 32'd1);
        checkOutput("drain_hold_busy", {31'd0, busy}, 32'd1);
        waitUntil(a + DRAIN + GUARD + 8);
        checkOutput("drain_off_len", seen_off, GUARD + 1);
        checkOutput("drain_mode", {29'd0, major_mode}, 32'd2);

        // Rejected frames: wrong length, then wrong opcode
        ssp_mode = 0;
        applyStimulus(32'h0830, 15, a);
        errs = 0;
        repeat (6) begin tick(); errs += int'(cmd_err); end
        checkOutput("rej_len_pulses", errs, 1);
        checkOutput("rej_len_mode", {29'd0, major_mode}, 32'd2);
        applyStimulus(32'h2020, 16, a);
        errs = 0;
        repeat (6) begin tick(); errs += int'(cmd_err); end
        checkOutput("rej_op_pulses", errs, 1);
        checkOutput("rej_op_sub", {27'd0, sub_conf}, 32'd0);

        // Retarget during BLANK: one blank period, and the latest target wins
        ssp_mode = 1;
        seen_off = 0;
        applyStimulus(32'h1080, 16, a);
        waitUntil(a + DRAIN + 5 - FRAME_ACT);
        applyStimulus(32'h1060, 16, a2);
        waitUntil(a + DRAIN + GUARD + 8);
        checkOutput("ovw_mode", {29'd0, major_mode}, 32'd3);
        checkOutput("ovw_off_len", seen_off, GUARD + 1);

        // A command landing in LOAD is parked and applied once back in IDLE
        seen_off = 0;
        applyStimulus(32'h1021, 16, a);
        waitUntil(a + DRAIN + GUARD + 1 - FRAME_ACT);
        applyStimulus(32'h1035, 16, a2);
        waitUntil(a2 + 3);
        checkOutput("pend_mode", {29'd0, major_mode}, 32'd1);
        checkOutput("pend_sub", {27'd0, sub_conf}, 32'h15);
        checkOutput("pend_busy", {31'd0, busy}, 32'd0);
        checkOutput("pend_off_len", seen_off, GUARD + 1);

        // Reset asserted mid-BLANK, then a full switch after release
        ssp_mode = 0;
        applyStimulus(32'h1040, 16, a);
        waitUntil(a + 5);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_mode", {29'd0, major_mode}, 32'd7);
        checkOutput("mid_rst_sub", {27'd0, sub_conf}, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_rst_err", {31'd0, cmd_err}, 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        applyStimulus(32'h1021, 16, a);
        waitUntil(a + GUARD + 3);
        checkOutput("post_rst_mode", {29'd0, major_mode}, 32'd1);
        checkOutput("post_rst_sub", {27'd0, sub_conf}, 32'd1);

        // Random frames with random ssp activity, checked cycle by cycle
        ssp_mode = 2;
        for (int k = 0; k < 30; k++) begin
            v = 32'h0;
            v[15:12] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0001;
            v[11:8]  = 4'($urandom_range(0, 15));
            v[7:5]   = 3'($urandom_range(0, 3));
            v[4:0]   = 5'($urandom_range(0, 31));
            nb = ($urandom_range(0, 5) == 0) ? $urandom_range(12, 20) : 16;
            applyStimulus(v, nb, a);
            repeat ($urandom_range(0, 60)) tick();
        end
        ssp_mode = 0;
        repeat (60) tick();
        checkOutput("final_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
